// File: rtl/pe_pkg.sv
// Shared PE definitions: controller state encodings and datapath width constants.
package pe_pkg;

  localparam int PE_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sersub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake between the PE controller and the serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             bin_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
  logic             zero_o;

  modport slave (
    input  start_i, a_i, b_i, bin_i,
    output busy_o, done_o, diff_o, borrow_o, zero_o
  );

  modport master (
    output start_i, a_i, b_i, bin_i,
    input  busy_o, done_o, diff_o, borrow_o, zero_o
  );

endinterface

// File: rtl/subtractor.sv
// 1-bit full subtractor cell: d = a - b - bin, bout set when the bit underflows.
module subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, through a single
// full-subtractor cell with a borrow flop closing the loop.
module serial_subtractor
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_DATA_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  serial_subtractor_if.slave  bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sersub_state_e    state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, diff_q;
  // Holds the WIDTH-1 lower result bits; the last bit comes straight from the cell.
  logic [WIDTH-2:0] res_sh_q, res_sh_d;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q, bout_q, zero_q;
  logic             cell_d, cell_b;

  subtractor u_cell (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cell_d),
    .bout_o (cell_b)
  );

  always_comb begin
    res_sh_d            = res_sh_q >> 1;
    res_sh_d[WIDTH-2]   = cell_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start_i) begin
            a_sh_q   <= bus.a_i;
            b_sh_q   <= bus.b_i;
            borrow_q <= bus.bin_i;
            cnt_q    <= '0;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          borrow_q <= cell_b;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_sh_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            diff_q  <= {cell_d, res_sh_q};
            bout_q  <= cell_b;
            zero_q  <= ({cell_d, res_sh_q} == '0);
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = (state_q == RUN);
  assign bus.done_o   = (state_q == DONE);
  assign bus.diff_o   = diff_q;
  assign bus.borrow_o = bout_q;
  assign bus.zero_o   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8: arithmetic corners, handshake
// timing, back-to-back operation and asynchronous reset mid-operation.
module tb_serial_subtractor;
  import pe_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request in cycle 0; it is accepted on the following rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.bin_i   = bin;
    @(posedge clk);
  endtask

  // Observe cycles 1..9 after acceptance. glitch_cyc pulses start with junk operands,
  // restart_cyc raises start with the supplied next operands (back-to-back).
  task automatic watch(input int glitch_cyc, input int restart_cyc,
                       input logic [W-1:0] na, input logic [W-1:0] nb, input logic nbin,
                       output int done_cyc, output int busy_cnt, output int done_cnt,
                       output logic [W-1:0] diff, output logic brw, output logic zr,
                       output logic held);
    logic [W-1:0] first_diff;
    done_cyc = 0; busy_cnt = 0; done_cnt = 0; held = 1'b1;
    diff = '0; brw = 1'b0; zr = 1'b0; first_diff = '0;
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (cyc == glitch_cyc) begin
        bus.start_i = 1'b1; bus.a_i = 8'hFF; bus.b_i = 8'h00; bus.bin_i = 1'b1;
      end
      if (cyc == restart_cyc) begin
        bus.start_i = 1'b1; bus.a_i = na; bus.b_i = nb; bus.bin_i = nbin;
      end
      if (cyc == 1) first_diff = bus.diff_o;
      if (bus.busy_o && bus.diff_o !== first_diff) held = 1'b0;
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = cyc;
        diff = bus.diff_o; brw = bus.borrow_o; zr = bus.zero_o;
      end
      @(posedge clk);
    end
  endtask

  int          dc, bc, dn;
  logic [W-1:0] d;
  logic        br, z, hd;

  task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] ed, input logic eb,
                          input logic ez);
    start_op(a, b, bin);
    watch(0, 0, '0, '0, 1'b0, dc, bc, dn, d, br, z, hd);
    chk({tag, "_diff"},   32'(d),  32'(ed));
    chk({tag, "_borrow"}, 32'(br), 32'(eb));
    chk({tag, "_zero"},   32'(z),  32'(ez));
    chk({tag, "_donecyc"}, 32'(dc), 32'd9);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.bin_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   32'(bus.busy_o),   32'd0);
    chk("rst_done",   32'(bus.done_o),   32'd0);
    chk("rst_diff",   32'(bus.diff_o),   32'd0);
    chk("rst_borrow", 32'(bus.borrow_o), 32'd0);
    chk("rst_zero",   32'(bus.zero_o),   32'd0);
    rst_n = 1'b1;

    // Basic op with full timing checks.
    start_op(8'h5A, 8'h23, 1'b0);
    watch(0, 0, '0, '0, 1'b0, dc, bc, dn, d, br, z, hd);
    chk("t1_diff",    32'(d),  32'h37);
    chk("t1_borrow",  32'(br), 32'd0);
    chk("t1_zero",    32'(z),  32'd0);
    chk("t1_donecyc", 32'(dc), 32'd9);
    chk("t1_donecnt", 32'(dn), 32'd1);
    chk("t1_busycnt", 32'(bc), 32'd8);
    @(negedge clk);
    chk("t1_idle_done", 32'(bus.done_o), 32'd0);
    chk("t1_hold_diff", 32'(bus.diff_o), 32'h37);

    op_check("t2",  8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
    op_check("t3a", 8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b1);
    op_check("t3b", 8'h42, 8'h42, 1'b1, 8'hFF, 1'b1, 1'b0);
    op_check("t4",  8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1);

    // Start pulse during RUN must be ignored; outputs hold the old result meanwhile.
    start_op(8'h5A, 8'h23, 1'b0);
    watch(3, 0, '0, '0, 1'b0, dc, bc, dn, d, br, z, hd);
    chk("ign_diff",    32'(d),  32'h37);
    chk("ign_donecyc", 32'(dc), 32'd9);
    chk("ign_busycnt", 32'(bc), 32'd8);
    chk("ign_hold",    32'(hd), 32'd1);
    @(negedge clk);
    chk("ign_no_rerun", 32'(bus.busy_o), 32'd0);

    // Back-to-back: start held through DONE launches the next op immediately.
    start_op(8'h10, 8'h20, 1'b0);
    watch(0, 9, 8'h01, 8'h02, 1'b0, dc, bc, dn, d, br, z, hd);
    chk("b2b1_diff",    32'(d),  32'hF0);
    chk("b2b1_donecyc", 32'(dc), 32'd9);
    watch(0, 0, '0, '0, 1'b0, dc, bc, dn, d, br, z, hd);
    chk("b2b2_donecyc", 32'(dc), 32'd9);
    chk("b2b2_busycnt", 32'(bc), 32'd8);
    chk("b2b2_diff",    32'(d),  32'hFF);
    chk("b2b2_borrow",  32'(br), 32'd1);
    chk("b2b2_zero",    32'(z),  32'd0);

    // Asynchronous reset after four bits have been processed.
    start_op(8'hFF, 8'h01, 1'b0);
    @(negedge clk); bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(bus.busy_o),   32'd0);
    chk("arst_done",   32'(bus.done_o),   32'd0);
    chk("arst_diff",   32'(bus.diff_o),   32'd0);
    chk("arst_borrow", 32'(bus.borrow_o), 32'd0);
    chk("arst_zero",   32'(bus.zero_o),   32'd0);
    chk("arst_state",  32'(dut.state_q),  32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    op_check("post_rst", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit unsigned subtractor for the PE datapath. Computes `a_i - b_i - bin_i` one bit per clock, LSB first, through a single instance of the team's 1-bit `subtractor` cell, with a borrow flip-flop closing the loop. Sits directly upstream of the PE result path. Trades WIDTH cycles of latency for one full-subtractor of logic, and exposes a start/busy/done handshake to the PE controller.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `start_i`  in  1: request; sampled only when `busy_o` = 0.
- `a_i`  in  WIDTH: minuend; captured on the accepted start edge.
- `b_i`  in  WIDTH: subtrahend; captured on the accepted start edge.
- `bin_i`  in  1: initial borrow; captured on the accepted start edge.
- `busy_o`  out  1: high while in RUN.
- `done_o`  out  1: one-cycle pulse; result valid.
- `diff_o`  out  WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `borrow_o`  out  1: final borrow; 1 iff `a < b + bin` (unsigned).
- `zero_o`  out  1: 1 iff `diff_o` == 0.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:** when `start_i` = 1:
  - load shift registers `a_sh` ← `a_i`, `b_sh` ← `b_i`, `borrow_q` ← `bin_i`, `cnt` ← 0;
  - go to RUN.
- **RUN:** the cell's inputs are `a_sh[0]`, `b_sh[0]` and `borrow_q`. On every edge:
  - `borrow_q` ← cell borrow;
  - `a_sh` and `b_sh` shift right by one;
  - the cell difference bit shifts into `res_sh[WIDTH-1]`, with `res_sh` shifting right;
  - `cnt` increments.
- **Leaving RUN:** when `cnt` = WIDTH-1, that edge also:
  - loads `diff_o` ← {cell diff, `res_sh[WIDTH-1:1]`};
  - loads `borrow_o` ← cell borrow and `zero_o` ← (that value == 0);
  - goes to DONE.
- **DONE:** `done_o` = 1 for exactly this cycle.
  - If `start_i` = 1, load exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- `start_i` while `busy_o` = 1 is ignored. It is neither queued nor an error.
- `diff_o`, `borrow_o` and `zero_o` are registered and hold their value until the next completion. They do not move during RUN.
- **Arithmetic:** unsigned, modulo 2^WIDTH. No overflow flag; `borrow_o` is the only out-of-range indication.
- **Counter:** `cnt` is `$clog2(WIDTH)` bits and never exceeds WIDTH-1.
- **Reset**, asserted at any time including mid-RUN:
  - state → IDLE;
  - all shift registers, `borrow_q` and `cnt` → 0;
  - `busy_o`, `done_o`, `diff_o`, `borrow_o` → 0;
  - `zero_o` → 0, because no result is valid yet;
  - the in-flight operation is discarded.

## Timing
- The start is accepted on edge E0; RUN occupies the WIDTH cycles following E0.
- `done_o` is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after the request was presented. For WIDTH = 8, `done_o` is high in cycle 9.
- `busy_o` is high for exactly WIDTH cycles per operation.
- Throughput: one result per WIDTH+1 cycles with `start_i` held high.
- `busy_o` and `done_o` are decoded from the state register with no combinational path from inputs. The only combinational path is the RUN-state path through the cell.

## Structure
- Shared package `pe_pkg` holds:
  - the state enum typedef `sersub_state_e` {IDLE, RUN, DONE};
  - any future PE-wide width constants.
- Exactly one sub-module: the existing 1-bit `subtractor` cell, instantiated once for the bit datapath.
- One sequential block covers the FSM, shift registers, counter and output registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, bin=0 → `diff_o`=0x37, `borrow_o`=0, `zero_o`=0; `done_o` high in cycle 9 only, `busy_o` high for cycles 1–8.
- a=0x10, b=0x20, bin=0 → `diff_o`=0xF0, `borrow_o`=1, `zero_o`=0.
- a=0x42, b=0x42:
  - with bin=0 → `diff_o`=0x00, `zero_o`=1, `borrow_o`=0;
  - rerun with bin=1 → `diff_o`=0xFF, `borrow_o`=1, `zero_o`=0.
- a=0x00, b=0xFF, bin=1 → `diff_o`=0x00, `borrow_o`=1, `zero_o`=1.
- Handshake:
  - pulse `start_i` with new operands during RUN → ignored, first result unchanged;
  - hold `start_i` high through DONE with a=0x01, b=0x02 → second `done_o` exactly 9 cycles after the first, with `diff_o`=0xFF, `borrow_o`=1.
- Drop `rst_ni` asynchronously after the 4th bit of a=0xFF, b=0x01 → all outputs 0 immediately and state IDLE. A fresh start after release yields the correct result 0xFE in cycle 9.
